// File: rtl/mac_dot_sequencer.sv
// Job controller for a 16x16 multiply-accumulate unit. It feeds one operand pair per accepted
// beat, waits out the MAC pipeline, then hands back the accumulated dot product.
module mac_dot_sequencer #(
    parameter int DW      = 16,
    parameter int ACC_W   = 36,
    parameter int LEN_W   = 8,
    parameter int MAC_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    output logic             busy,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [DW-1:0]    s_a,
    input  logic [DW-1:0]    s_b,
    output logic [DW-1:0]    mac_a,
    output logic [DW-1:0]    mac_b,
    output logic             mac_clr,
    input  logic [ACC_W-1:0] mac_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_data
);

    localparam int DCW = $clog2(MAC_LAT + 2);
    localparam logic [LEN_W-1:0] REM_ZERO   = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] REM_ONE    = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [DCW-1:0]   DC_ONE     = {{(DCW-1){1'b0}}, 1'b1};
    localparam logic [DCW-1:0]   DRAIN_LOAD = DCW'(MAC_LAT + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t           state_r, state_s;
    logic [LEN_W-1:0] rem_r, rem_s;
    logic [DCW-1:0]   dcnt_r, dcnt_s;
    logic             accept_s;
    logic             abort_take_s;
    logic             capture_s;

    logic             busy_r;
    logic             s_ready_r;
    logic             mac_clr_r;
    logic             res_valid_r;
    logic [DW-1:0]    mac_a_r;
    logic [DW-1:0]    mac_b_r;
    logic [ACC_W-1:0] res_data_r;

    // Next-state, counter updates and per-cycle strobes
    always_comb begin
        state_s      = state_r;
        rem_s        = rem_r;
        dcnt_s       = dcnt_r;
        accept_s     = 1'b0;
        abort_take_s = 1'b0;
        capture_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    rem_s   = len;
                    state_s = CLEAR;
                end else begin
                    state_s = IDLE;
                end
            end
            CLEAR: begin
                if (rem_r != REM_ZERO) begin
                    state_s = FEED;
                end else begin
                    state_s = DRAIN;
                    dcnt_s  = DRAIN_LOAD;
                end
            end
            FEED: begin
                // abort outranks a beat presented in the same cycle
                if (abort) begin
                    abort_take_s = 1'b1;
                    state_s      = IDLE;
                end else if (s_valid) begin
                    accept_s = 1'b1;
                    rem_s    = rem_r - REM_ONE;
                    if (rem_r == REM_ONE) begin
                        state_s = DRAIN;
                        dcnt_s  = DRAIN_LOAD;
                    end else begin
                        state_s = FEED;
                    end
                end else begin
                    state_s = FEED;
                end
            end
            DRAIN: begin
                if (abort) begin
                    abort_take_s = 1'b1;
                    state_s      = IDLE;
                end else if (dcnt_r == DC_ONE) begin
                    capture_s = 1'b1;
                    state_s   = DONE;
                end else begin
                    dcnt_s  = dcnt_r - DC_ONE;
                    state_s = DRAIN;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs derived from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            rem_r       <= REM_ZERO;
            dcnt_r      <= {DCW{1'b0}};
            busy_r      <= 1'b0;
            s_ready_r   <= 1'b0;
            mac_clr_r   <= 1'b0;
            res_valid_r <= 1'b0;
            mac_a_r     <= {DW{1'b0}};
            mac_b_r     <= {DW{1'b0}};
            res_data_r  <= {ACC_W{1'b0}};
        end else begin
            state_r     <= state_s;
            rem_r       <= rem_s;
            dcnt_r      <= dcnt_s;
            busy_r      <= (state_s != IDLE);
            s_ready_r   <= (state_s == FEED);
            mac_clr_r   <= (state_s == CLEAR) || abort_take_s;
            res_valid_r <= (state_s == DONE);
            // zero operands on non-beat cycles keep the accumulator still
            mac_a_r     <= accept_s ? s_a : {DW{1'b0}};
            mac_b_r     <= accept_s ? s_b : {DW{1'b0}};
            res_data_r  <= capture_s ? mac_out : res_data_r;
        end
    end

    assign busy      = busy_r;
    assign s_ready   = s_ready_r;
    assign mac_clr   = mac_clr_r;
    assign res_valid = res_valid_r;
    assign mac_a     = mac_a_r;
    assign mac_b     = mac_b_r;
    assign res_data  = res_data_r;

endmodule
